operand_seq_ctrl: RTL and testbench
===================================

OPERAND_SEQ_CTRL -- requirements
Module: operand_seq_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1024: max cycles waited for op_done before error.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port key_valid  input  1  one-cycle pulse, key code present.
REQ-005 SHALL have port key  input  4  key code; 0x0-0x9 digit, 0xA enter, 0xC clear, others ignored.
REQ-006 SHALL have port op_done  input  1  operation-complete pulse from arithmetic unit.
REQ-007 SHALL have port num  output  8  operand value under entry (accumulator), feeds operand register data input.
REQ-008 SHALL have port load_a  output  1  one-cycle load strobe, operand A.
REQ-009 SHALL have port load_b  output  1  one-cycle load strobe, operand B.
REQ-010 SHALL have port op_start  output  1  one-cycle start strobe to arithmetic unit.
REQ-011 SHALL have port busy  output  1  high in LOAD_B, START, WAIT.
REQ-012 SHALL have port stage  output  2  0 entering A, 1 entering B, 2 computing, 3 result/error.
REQ-013 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-014 SHALL implement FSM states ENTER_A, LOAD_A, ENTER_B, LOAD_B, START, WAIT, RESULT, ERROR.
REQ-015 SHALL, in ENTER_A/ENTER_B on digit d, set acc = acc*10+d and digit_cnt+1 only if digit_cnt<3 and result <=255; otherwise ignore key (no saturation, no wrap).
REQ-016 SHALL compute acc*10+d in at least 12 bits before the <=255 compare.
REQ-017 SHALL drive num = acc continuously.
REQ-018 SHALL ignore enter when digit_cnt==0.
REQ-019 SHALL on accepted enter go ENTER_A->LOAD_A (ENTER_B->LOAD_B); LOAD states last exactly one cycle, assert load_a (load_b) with num still holding acc, then clear acc and digit_cnt on exit.
REQ-020 SHALL go LOAD_A->ENTER_B, LOAD_B->START, START->WAIT; op_start high only in START.
REQ-021 SHALL never assert load_a and load_b in the same cycle.
REQ-022 SHALL in WAIT count cycles from 0; op_done -> RESULT; no op_done by count TIMEOUT_CYC-1 -> ERROR, err set.
REQ-023 SHALL give op_done priority when it coincides with the timeout cycle.
REQ-024 SHALL ignore op_done outside WAIT.
REQ-025 SHALL on clear in ENTER_A, ENTER_B, RESULT or ERROR go to ENTER_A, clear acc, digit_cnt, err.
REQ-026 SHALL ignore all keys in LOAD_A, LOAD_B, START, WAIT.
REQ-027 SHALL ignore digits and enter in RESULT and ERROR.
REQ-028 SHALL drive load_a, load_b, op_start, busy, stage as Moore outputs of state.

Reset
REQ-029 SHALL on rst=1 at a clock edge set state ENTER_A, acc 0, digit_cnt 0, timer 0, err 0; outputs num 0, strobes 0, busy 0, stage 0.
REQ-030 SHALL let rst override any state including LOAD/START/WAIT; no strobe asserted in the cycle after reset.

Structure
REQ-031 SHALL place state enum, KEY_ENTER=4'hA, KEY_CLEAR=4'hC, MAX_DIGITS=3 in shared package opctrl_pkg.
REQ-032 SHALL implement decimal accumulation (acc, digit_cnt, bound check) in sub-module operand_accum; FSM and timer in top.

Verification
REQ-033 SHALL cover: keys 1,2,A -> load_a one cycle with num=12, then stage=1, num=0.
REQ-034 SHALL cover: keys 2,5,6 in ENTER_A -> third digit ignored, num=25; keys 1,2,3,4 -> num=123.
REQ-035 SHALL cover: A=7, B=3 entered, op_done 5 cycles after op_start -> single op_start, busy high through WAIT, stage=3, err=0.
REQ-036 SHALL cover: TIMEOUT_CYC=16, no op_done -> ERROR exactly 16 cycles after WAIT entry, err=1; clear -> stage=0, err=0.
REQ-037 SHALL cover: op_done on cycle 15 with TIMEOUT_CYC=16 -> RESULT, err=0.
REQ-038 SHALL cover: rst asserted during WAIT -> next cycle stage=0, busy=0, num=0, no strobes.

Source files
------------

// File: rtl/opctrl_pkg.sv
// Shared types and constants for the operand entry / sequencing controller.
package opctrl_pkg;

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    LOAD_A  = 3'd1,
    ENTER_B = 3'd2,
    LOAD_B  = 3'd3,
    START   = 3'd4,
    WAIT    = 3'd5,
    RESULT  = 3'd6,
    ERROR   = 3'd7
  } state_t;

  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CLEAR  = 4'hC;
  localparam int         MAX_DIGITS = 3;
  localparam int         ACC_W      = 8;

endpackage

// File: rtl/operand_accum.sv
// Decimal operand accumulator: builds a value of up to MAX_DIGITS digits,
// refusing any digit that would push the value past 255 or exceed the digit count.
module operand_accum
  import opctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             digit_en,
  input  logic [3:0]       digit,
  input  logic             clr,
  output logic [ACC_W-1:0] acc,
  output logic [1:0]       digit_cnt
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

  // Candidate value is formed wide enough (12 bits) that 255*10+9 cannot wrap.
  logic [11:0] next_val;
  logic        accept;

  assign next_val = ({4'b0, acc} * 12'd10) + {8'b0, digit};
  assign accept   = digit_en && (digit_cnt < MAX_CNT) && (next_val <= 12'd255);

  // Accumulator and digit counter; clear wins over a new digit.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc       <= '0;
      digit_cnt <= '0;
    end else if (accept) begin
      acc       <= next_val[ACC_W-1:0];
      digit_cnt <= digit_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/operand_seq_ctrl.sv
// Operand sequencing controller: takes two decimal operands from a keypad,
// strobes them into operand registers, starts the arithmetic unit and
// supervises completion with a timeout.
module operand_seq_ctrl
  import opctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key,
  input  logic       op_done,
  output logic [7:0] num,
  output logic       load_a,
  output logic       load_b,
  output logic       op_start,
  output logic       busy,
  output logic [1:0] stage,
  output logic       err
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_t          state, state_nxt;
  logic [TW-1:0]   timer;
  logic [1:0]      digit_cnt;
  logic            in_entry;
  logic            key_digit;
  logic            key_enter;
  logic            clear_ok;
  logic            timeout;
  logic            acc_clr;

  assign in_entry  = (state == ENTER_A) || (state == ENTER_B);
  assign key_digit = key_valid && (key <= 4'h9);
  assign key_enter = key_valid && (key == KEY_ENTER) && (digit_cnt != 2'd0);
  assign clear_ok  = key_valid && (key == KEY_CLEAR) &&
                     (in_entry || (state == RESULT) || (state == ERROR));
  // op_done on the last allowed cycle takes priority over the timeout.
  assign timeout   = (state == WAIT) && !op_done && (timer == TW'(TIMEOUT_CYC - 1));
  // The operand is consumed on the cycle after its load strobe.
  assign acc_clr   = (state == LOAD_A) || (state == LOAD_B) || clear_ok;

  operand_accum u_accum (
    .clk       (clk),
    .rst       (rst),
    .digit_en  (key_digit && in_entry),
    .digit     (key),
    .clr       (acc_clr),
    .acc       (num),
    .digit_cnt (digit_cnt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ENTER_A;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ENTER_A: begin
        if (clear_ok)       state_nxt = ENTER_A;
        else if (key_enter) state_nxt = LOAD_A;
      end
      LOAD_A:  state_nxt = ENTER_B;
      ENTER_B: begin
        if (clear_ok)       state_nxt = ENTER_A;
        else if (key_enter) state_nxt = LOAD_B;
      end
      LOAD_B:  state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT: begin
        if (op_done)        state_nxt = RESULT;
        else if (timeout)   state_nxt = ERROR;
      end
      RESULT, ERROR: begin
        if (clear_ok)       state_nxt = ENTER_A;
      end
      default:              state_nxt = ENTER_A;
    endcase
  end

  // Wait timer: counts cycles spent in WAIT, held at zero elsewhere.
  always_ff @(posedge clk) begin
    if (rst || (state != WAIT)) timer <= '0;
    else                        timer <= timer + 1'b1;
  end

  // Sticky timeout flag, released only by clear or reset.
  always_ff @(posedge clk) begin
    if (rst)           err <= 1'b0;
    else if (timeout)  err <= 1'b1;
    else if (clear_ok) err <= 1'b0;
  end

  // Moore output decode.
  always_comb begin
    load_a   = 1'b0;
    load_b   = 1'b0;
    op_start = 1'b0;
    busy     = 1'b0;
    stage    = 2'd0;
    case (state)
      ENTER_A: stage = 2'd0;
      LOAD_A:  begin load_a = 1'b1; stage = 2'd0; end
      ENTER_B: stage = 2'd1;
      LOAD_B:  begin load_b = 1'b1; busy = 1'b1; stage = 2'd1; end
      START:   begin op_start = 1'b1; busy = 1'b1; stage = 2'd2; end
      WAIT:    begin busy = 1'b1; stage = 2'd2; end
      RESULT, ERROR: stage = 2'd3;
      default: stage = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_operand_seq_ctrl.sv
// Self-checking bench for operand_seq_ctrl: directed scenarios plus a
// randomized key/op_done stream compared against a behavioural model.
module tb_operand_seq_ctrl;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key = 4'h0;
  logic       op_done = 1'b0;
  logic [7:0] num;
  logic       load_a, load_b, op_start, busy, err;
  logic [1:0] stage;

  int errors = 0;
  int checks = 0;

  operand_seq_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key(key), .op_done(op_done),
    .num(num), .load_a(load_a), .load_b(load_b), .op_start(op_start),
    .busy(busy), .stage(stage), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock with the given inputs; outputs are stable when it returns.
  task automatic step(input logic kv, input logic [3:0] k, input logic od);
    key_valid = kv; key = k; op_done = od;
    @(posedge clk); #1;
    key_valid = 1'b0; op_done = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 1'b0);
  endtask

  task automatic press(input logic [3:0] k);
    step(1'b1, k, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    rst = 1'b0;
  endtask

  // Enter both operands and land on the first WAIT cycle.
  task automatic go_wait(input logic [3:0] a, input logic [3:0] b);
    do_reset();
    press(a); press(4'hA); idle();
    press(b); press(4'hA); idle(); idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(); idle();
    checks++;
    if ({num, load_a, load_b, op_start, busy, stage, err} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {num, load_a, load_b, op_start, busy, stage, err});
    end
    rst = 1'b0;
  endtask

  task automatic test_load_a();
    do_reset();
    press(4'h1); press(4'h2);
    checks++;
    if (num !== 8'd12) begin errors++; $display("FAIL num_12: got %0d required 12", num); end
    press(4'hA);
    checks++;
    if ({load_a, load_b, stage, num} !== {1'b1, 1'b0, 2'd0, 8'd12}) begin
      errors++;
      $display("FAIL load_a_strobe: got la=%b lb=%b st=%0d num=%0d required la=1 lb=0 st=0 num=12",
               load_a, load_b, stage, num);
    end
    idle();
    checks++;
    if ({load_a, stage, num} !== {1'b0, 2'd1, 8'd0}) begin
      errors++;
      $display("FAIL after_load_a: got la=%b st=%0d num=%0d required la=0 st=1 num=0",
               load_a, stage, num);
    end
  endtask

  task automatic test_digit_limits();
    do_reset();
    // Enter with no digits must be ignored.
    press(4'hA);
    checks++;
    if ({load_a, stage} !== {1'b0, 2'd0}) begin
      errors++; $display("FAIL empty_enter: got la=%b st=%0d required la=0 st=0", load_a, stage);
    end
    press(4'h2); press(4'h5); press(4'h6);
    checks++;
    if (num !== 8'd25) begin errors++; $display("FAIL overflow_ignored: got %0d required 25", num); end
    press(4'hC);
    checks++;
    if (num !== 8'd0) begin errors++; $display("FAIL clear_num: got %0d required 0", num); end
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    checks++;
    if (num !== 8'd123) begin errors++; $display("FAIL max_digits: got %0d required 123", num); end
    do_reset();
    press(4'h2); press(4'h5); press(4'h5);
    checks++;
    if (num !== 8'd255) begin errors++; $display("FAIL value_255: got %0d required 255", num); end
  endtask

  task automatic test_compute();
    int starts;
    starts = 0;
    do_reset();
    press(4'h7); press(4'hA);
    checks++;
    if ({load_a, load_b, num} !== {1'b1, 1'b0, 8'd7}) begin
      errors++; $display("FAIL load_a_7: got la=%b lb=%b num=%0d required la=1 lb=0 num=7", load_a, load_b, num);
    end
    idle(); press(4'h3); press(4'hA);
    checks++;
    if ({load_a, load_b, busy, stage, num} !== {1'b0, 1'b1, 1'b1, 2'd1, 8'd3}) begin
      errors++;
      $display("FAIL load_b_3: got la=%b lb=%b busy=%b st=%0d num=%0d required la=0 lb=1 busy=1 st=1 num=3",
               load_a, load_b, busy, stage, num);
    end
    idle();
    starts += int'(op_start);
    checks++;
    if ({op_start, busy, stage} !== {1'b1, 1'b1, 2'd2}) begin
      errors++; $display("FAIL start: got os=%b busy=%b st=%0d required os=1 busy=1 st=2", op_start, busy, stage);
    end
    for (int i = 0; i < 4; i++) begin
      idle();
      starts += int'(op_start);
      checks++;
      if ({busy, stage, load_a, load_b} !== {1'b1, 2'd2, 1'b0, 1'b0}) begin
        errors++; $display("FAIL wait_busy: got busy=%b st=%0d required busy=1 st=2", busy, stage);
      end
    end
    step(1'b0, 4'h0, 1'b1);
    starts += int'(op_start);
    checks++;
    if ({stage, busy, err} !== {2'd3, 1'b0, 1'b0}) begin
      errors++; $display("FAIL result: got st=%0d busy=%b err=%b required st=3 busy=0 err=0", stage, busy, err);
    end
    checks++;
    if (starts !== 1) begin errors++; $display("FAIL single_start: got %0d required 1", starts); end
  endtask

  task automatic test_timeout();
    go_wait(4'h4, 4'h5);
    for (int i = 1; i < TO; i++) idle();
    checks++;
    if ({stage, busy, err} !== {2'd2, 1'b1, 1'b0}) begin
      errors++; $display("FAIL pre_timeout: got st=%0d busy=%b err=%b required st=2 busy=1 err=0", stage, busy, err);
    end
    idle();
    checks++;
    if ({stage, busy, err} !== {2'd3, 1'b0, 1'b1}) begin
      errors++; $display("FAIL timeout: got st=%0d busy=%b err=%b required st=3 busy=0 err=1", stage, busy, err);
    end
    press(4'h5); press(4'hA);
    checks++;
    if ({stage, err, num, load_a} !== {2'd3, 1'b1, 8'd0, 1'b0}) begin
      errors++; $display("FAIL error_ignores_keys: got st=%0d err=%b num=%0d la=%b", stage, err, num, load_a);
    end
    press(4'hC);
    checks++;
    if ({stage, err} !== {2'd0, 1'b0}) begin
      errors++; $display("FAIL error_clear: got st=%0d err=%b required st=0 err=0", stage, err);
    end
  endtask

  task automatic test_late_done();
    go_wait(4'h9, 4'h1);
    for (int i = 1; i < TO; i++) idle();
    step(1'b0, 4'h0, 1'b1);
    checks++;
    if ({stage, err} !== {2'd3, 1'b0}) begin
      errors++; $display("FAIL late_done: got st=%0d err=%b required st=3 err=0", stage, err);
    end
  endtask

  task automatic test_reset_in_wait();
    go_wait(4'h8, 4'h2);
    idle(); idle();
    press(4'h6); // ignored in WAIT
    rst = 1'b1;
    idle();
    rst = 1'b0;
    checks++;
    if ({stage, busy, num, load_a, load_b, op_start, err} !== 15'd0) begin
      errors++;
      $display("FAIL reset_in_wait: got st=%0d busy=%b num=%0d la=%b lb=%b os=%b err=%b required all 0",
               stage, busy, num, load_a, load_b, op_start, err);
    end
    idle();
    checks++;
    if ({load_a, load_b, op_start, stage} !== 5'd0) begin
      errors++; $display("FAIL post_reset_idle: got la=%b lb=%b os=%b st=%0d required 0", load_a, load_b, op_start, stage);
    end
  endtask

  // Random keys and op_done against a model that tracks the entry phase,
  // the operand being typed and any pending automatic strobe sequence.
  task automatic test_random();
    int phase, val, nd, pend, elapsed;
    bit m_err;
    logic kv, od;
    logic [3:0] k;
    logic [14:0] exp_v, got_v;
    int r;
    do_reset();
    phase = 0; val = 0; nd = 0; pend = 0; elapsed = 0; m_err = 0;
    for (int c = 0; c < 1500; c++) begin
      kv = ($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 99);
      if (r < 60)      k = 4'($urandom_range(0, 9));
      else if (r < 78) k = 4'hA;
      else if (r < 86) k = 4'hC;
      else             k = 4'($urandom_range(11, 15));
      od = ($urandom_range(0, 11) == 0);
      step(kv, k, od);
      // pend: 1 = loading A, 2 = loading B, 3 = starting
      if (pend == 1) begin
        pend = 0; val = 0; nd = 0; phase = 1;
      end else if (pend == 2) begin
        pend = 3; val = 0; nd = 0; phase = 2;
      end else if (pend == 3) begin
        pend = 0; elapsed = 0;
      end else if (phase == 2) begin
        if (od) phase = 3;
        else if (elapsed == TO - 1) begin phase = 3; m_err = 1; end
        else elapsed++;
      end else if (kv && k == 4'hC) begin
        phase = 0; val = 0; nd = 0; m_err = 0;
      end else if (phase < 2 && kv && k <= 4'h9) begin
        if (nd < 3 && val * 10 + int'(k) <= 255) begin
          val = val * 10 + int'(k); nd++;
        end
      end else if (phase < 2 && kv && k == 4'hA && nd > 0) begin
        pend = (phase == 0) ? 1 : 2;
      end
      exp_v = {8'(val), pend == 1, pend == 2, pend == 3,
               (pend == 2) || (phase == 2), 2'(phase), m_err};
      got_v = {num, load_a, load_b, op_start, busy, stage, err};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL random_cycle_%0d: got num=%0d la=%b lb=%b os=%b busy=%b st=%0d err=%b required %h",
                 c, num, load_a, load_b, op_start, busy, stage, err, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_a();
    test_digit_limits();
    test_compute();
    test_timeout();
    test_late_done();
    test_reset_in_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
